chien_root_search: RTL
======================

Name: chien_root_search

Overview:
- Chien search stage directly downstream of the sigma degree detector in the RS(544,522) decoder.
- Accepts the error-locator polynomial sigma (low order first) and its degree. Evaluates sigma at alpha^-j for every codeword position j = 0..N-1, one position per cycle.
- Emits a per-position root flag for the Forney/correction stage.
- Ends each search with a root count and a decode-failure flag.

Parameters:
- W, 10, GF(2^m) symbol width.
- T, 11, maximum sigma degree; coefficients sigma[0..T].
- N, 544, shortened codeword length; number of positions searched.
- PRIM_POLY, 10'h009, low W bits of the primitive polynomial x^10+x^3+1.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous, active-high reset
- sigma_low_i  input  W x [0:T]  sigma coefficients, lambda0 first
- sigma_deg_i  input  $clog2(T+1)  deg(sigma) from the degree detector
- start_i  input  1  start request
- sigma_valid_i  input  1  sigma/degree valid; accepted only together with start_i
- ready_o  output  1  high in IDLE
- loc_valid_o  output  1  position result valid
- loc_idx_o  output  $clog2(N)  position index j
- is_root_o  output  1  sigma(alpha^-j) == 0
- done_o  output  1  one-cycle end-of-search pulse
- root_cnt_o  output  $clog2(T+1)  number of roots found
- fail_o  output  1  uncorrectable; valid with done_o

Behaviour:
- One clock, clk_i. rst_i is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - ready_o = 1.
  - loc_valid_o, is_root_o, done_o, fail_o = 0.
  - loc_idx_o, root_cnt_o = 0.
  - term registers = 0, degree register = 0.
- States: IDLE, EVAL, DONE.
- IDLE:
  - ready_o = 1.
  - Accept when start_i && sigma_valid_i in the same cycle.
  - On accept: term[i] <= sigma_low_i[i] for all i, deg_q <= sigma_deg_i, j counter <= 0, root count <= 0, go to EVAL.
  - start_i without sigma_valid_i, or sigma_valid_i without start_i: ignored.
- EVAL:
  - ready_o = 0.
  - Each cycle: loc_valid_o = 1, loc_idx_o = j, is_root_o = (XOR over i of term[i]) == 0. These outputs are combinational from the registers.
  - Each cycle: term[i] <= term[i] * alpha^-i, where alpha^-i = alpha^(1023-i) is a constant GF multiply generated from PRIM_POLY. term[0] is unchanged.
  - If is_root, root count increments. The count saturates at 2^width-1 and cannot wrap.
  - j increments each cycle.
  - First position (j=0) appears the cycle after accept. Positions run contiguously, N cycles total.
  - After j = N-1, go to DONE.
- DONE, one cycle:
  - done_o = 1, loc_valid_o = 0.
  - root_cnt_o = final count.
  - fail_o = (root count != deg_q).
  - Then return to IDLE.
- Done timing: done_o asserts exactly N+1 cycles after the accept cycle.
- root_cnt_o and fail_o hold their values until the next accept.
- start_i in EVAL or DONE: ignored. No queuing; upstream must wait for ready_o.
- deg_q = 0 (sigma = constant): no roots expected; fail_o = 0 if 0 roots found.
- lambda0 = 0: search runs normally, with no special handling.
- Roots at field positions j >= N (outside the shortened code) are never visited. The resulting count mismatch sets fail_o.
- rst_i asserted mid-EVAL or in DONE: next cycle is IDLE with reset values. No done_o is emitted for the aborted search.
- All GF arithmetic is XOR add plus constant multiply modulo PRIM_POLY. No pipelining inside the evaluation loop.

Test Plan:
- sigma = {1,0,...}, deg = 0, start+valid -> 544 loc_valid cycles, all is_root = 0. done_o at accept+545 with root_cnt = 0, fail = 0.
- sigma = 1 + alpha^5·x, deg = 1 -> is_root = 1 only at loc_idx = 5. done_o with root_cnt = 1, fail = 0.
- sigma = (1+x)(1+alpha^543·x), deg = 2 -> roots at loc_idx 0 and 543 only. root_cnt = 2, fail = 0.
- sigma = 1 + alpha^600·x, deg = 1 (root outside the shortened code) -> no is_root. root_cnt = 0, fail = 1.
- start_i without sigma_valid_i in IDLE -> no accept, ready_o stays 1. start+valid at EVAL cycle 100 -> ignored, the running search completes unchanged.
- rst_i at EVAL cycle 200 -> next cycle IDLE, ready_o = 1, all other outputs 0, no done_o. A new accept afterwards runs a full 544-position search.

Source files
------------

// File: rtl/chien_root_search.sv
// Chien search for RS(544,522): evaluates sigma at alpha^-j for j = 0..N-1, one
// position per cycle, then reports the root count and a decode-failure flag.
module chien_root_search #(
  parameter int             W         = 10,
  parameter int             T         = 11,
  parameter int             N         = 544,
  parameter logic [W-1:0]   PRIM_POLY = 10'h009,
  localparam int            DW        = $clog2(T+1),
  localparam int            IW        = $clog2(N)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [(T+1)*W-1:0]   sigma_low_i,
  input  logic [DW-1:0]        sigma_deg_i,
  input  logic                 start_i,
  input  logic                 sigma_valid_i,
  output logic                 ready_o,
  output logic                 loc_valid_o,
  output logic [IW-1:0]        loc_idx_o,
  output logic                 is_root_o,
  output logic                 done_o,
  output logic [DW-1:0]        root_cnt_o,
  output logic                 fail_o
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  // Generic GF(2^W) multiply; with one operand constant it folds to an XOR network.
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p;
    p = '0;
    for (int k = W-1; k >= 0; k--) begin
      p = {p[W-2:0], 1'b0} ^ (p[W-1] ? PRIM_POLY : '0);
      if (b[k]) p = p ^ a;
    end
    return p;
  endfunction

  // alpha^-k built by k divisions by alpha (x^W is implicit in PRIM_POLY).
  function automatic logic [W-1:0] alpha_inv_pow(input int k);
    logic [W-1:0] p;
    logic [W-1:0] r;
    p = W'(1);
    for (int n = 0; n < k; n++) begin
      r = p ^ PRIM_POLY;
      p = p[0] ? {1'b1, r[W-1:1]} : {1'b0, p[W-1:1]};
    end
    return p;
  endfunction

  state_t          state_q, state_d;
  logic [W-1:0]    term_q [0:T];
  logic [W-1:0]    term_d [0:T];
  logic [W-1:0]    term_step [0:T];
  logic [DW-1:0]   deg_q, deg_d;
  logic [IW-1:0]   j_q, j_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic            fail_q, fail_d;
  logic [W-1:0]    sum;
  logic            root_hit;
  logic            accept;
  logic            last_pos;

  for (genvar i = 0; i <= T; i++) begin : g_step
    localparam logic [W-1:0] ALPHA_INV_I = alpha_inv_pow(i);
    assign term_step[i] = gf_mul(term_q[i], ALPHA_INV_I);
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i <= T; i++) sum = sum ^ term_q[i];
  end

  assign accept   = (state_q == IDLE) && start_i && sigma_valid_i;
  assign root_hit = (state_q == EVAL) && (sum == '0);
  assign last_pos = (j_q == IW'(N-1));

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EVAL;
      EVAL:    if (last_pos) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready_o     = (state_q == IDLE);
    loc_valid_o = (state_q == EVAL);
    loc_idx_o   = (state_q == EVAL) ? j_q : '0;
    is_root_o   = root_hit;
    done_o      = (state_q == DONE);
    root_cnt_o  = cnt_q;
    fail_o      = fail_q;
  end

  // Datapath next-state: load on accept, step the terms while evaluating.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    term_d = term_q;
    deg_d  = deg_q;
    j_d    = j_q;
    cnt_d  = cnt_q;
    fail_d = fail_q;
    if (accept) begin
      for (int i = 0; i <= T; i++) term_d[i] = sigma_low_i[i*W +: W];
      deg_d  = sigma_deg_i;
      j_d    = '0;
      cnt_d  = '0;
      fail_d = 1'b0;
    end else if (state_q == EVAL) begin
      term_d = term_step;
      j_d    = j_q + IW'(1);
      if (root_hit && (cnt_q != '1)) cnt_d = cnt_q + DW'(1);
      if (last_pos) fail_d = (cnt_d != deg_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i <= T; i++) term_q[i] <= '0;
      deg_q  <= '0;
      j_q    <= '0;
      cnt_q  <= '0;
      fail_q <= 1'b0;
    end else begin
      term_q <= term_d;
      deg_q  <= deg_d;
      j_q    <= j_d;
      cnt_q  <= cnt_d;
      fail_q <= fail_d;
    end
  end

endmodule
